minv_result_out: RTL and testbench



---
 rtl/minv_result_out.sv | 126 ++++++++++++
 tb/tb_minv_result_out.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minv_result_out.sv
// Snapshots the modular-inverse result register chosen by minv_flag and streams it out LS word first.
// Define MINV_FINAL_SUB_EN to add a final conditional subtraction of p before streaming.
module minv_result_out #(
    parameter int WIDTH = 256,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       minv_flag,
    input  logic [WIDTH-1:0] regx1,
    input  logic [WIDTH-1:0] regx2,
    input  logic [WIDTH-1:0] regt,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_last
);

    localparam int NBEATS = WIDTH / WORD;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef MINV_FINAL_SUB_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_SEND   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd2
    } state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] buffer;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sel_reg;

    always_comb begin
        sel_reg = regx1;
        case (minv_flag)
            2'b01:   sel_reg = regx2;
            2'b11:   sel_reg = regt;
            default: sel_reg = regx1;
        endcase
    end

`ifdef MINV_FINAL_SUB_EN
    // Inputs to the inverse are already below p, so one subtraction yields the canonical residue.
    logic [WIDTH-1:0] reduced;
    assign reduced = (buffer >= p) ? (buffer - p) : buffer;
`else
    logic unused_p;
    assign unused_p = ^p;
`endif

    // The buffer drains to zero as it is shifted, so the beat port rests at zero in IDLE.
    assign out_data = buffer[WORD-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            buffer    <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (minv_flag == 2'b10) begin
                            err <= 1'b1;
                        end else begin
                            buffer <= sel_reg;
                            cnt    <= '0;
                            busy   <= 1'b1;
`ifdef MINV_FINAL_SUB_EN
                            state  <= S_REDUCE;
`else
                            state     <= S_SEND;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef MINV_FINAL_SUB_EN
                S_REDUCE: begin
                    buffer    <= reduced;
                    state     <= S_SEND;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end
`endif
                S_SEND: begin
                    if (out_ready) begin
                        buffer <= buffer >> WORD;
                        cnt    <= cnt + CNT_ONE;
                        if (out_last) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_last <= ((cnt + CNT_ONE) == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minv_result_out.sv
// Scoreboard bench for minv_result_out at WIDTH=64, WORD=16; expected beats are queued
// by the stimulus and popped by an independent monitor on each accepted beat.
module tb_minv_result_out;

    localparam int WIDTH = 64;
    localparam int WORD  = 16;

`ifdef MINV_FINAL_SUB_EN
    localparam int LAT = 2;
    localparam logic [15:0] SMALL_BEAT0 = 16'h0035;
    localparam logic [15:0] EQUAL_BEAT0 = 16'h0000;
`else
    localparam int LAT = 1;
    localparam logic [15:0] SMALL_BEAT0 = 16'h0096;
    localparam logic [15:0] EQUAL_BEAT0 = 16'h0096;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       minv_flag = 2'b00;
    logic [WIDTH-1:0] regx1 = '0;
    logic [WIDTH-1:0] regx2 = '0;
    logic [WIDTH-1:0] regt = '0;
    logic [WIDTH-1:0] p = '0;
    logic             busy;
    logic             err;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WORD-1:0]  out_data;
    logic             out_last;

    int checks = 0;
    int failures = 0;
    int xfers = 0;
    logic [WORD:0] expq[$];
    logic          stall_prev = 1'b0;
    logic          idle_next = 1'b0;
    logic [WORD-1:0] held_data = '0;
    logic          held_last = 1'b0;

    minv_result_out #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .minv_flag(minv_flag),
        .regx1(regx1),
        .regx2(regx2),
        .regt(regt),
        .p(p),
        .busy(busy),
        .err(err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushBeat(input logic [15:0] data, input logic last);
        expq.push_back({last, data});
    endtask

    task automatic applyStimulus(input logic [1:0] flag, input logic [63:0] x1,
                                 input logic [63:0] x2, input logic [63:0] t,
                                 input logic [63:0] pv);
        @(posedge clk); #1;
        minv_flag = flag;
        regx1 = x1;
        regx2 = x2;
        regt = t;
        p = pv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        minv_flag = 2'b10;
        regx1 = 64'hDEAD_BEEF_DEAD_BEEF;
        regx2 = 64'hDEAD_BEEF_DEAD_BEEF;
        regt = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    // Waits for the stream to finish, counting busy cycles from the one after the start edge.
    task automatic runStream(input string name, input int exp_busy);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checkOutput({name, " busy after start"}, 64'(busy), 64'd1);
                checkOutput({name, " first valid latency"}, 64'(out_valid), 64'(LAT == 1));
            end
            if (busy) n++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: busy still high", name);
        end
        checkOutput({name, " busy cycles"}, 64'(n), 64'(exp_busy));
    endtask

    // Monitor: pops the scoreboard on each accepted beat and checks stall stability and drain.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            idle_next = 1'b0;
        end else begin
            if (idle_next) begin
                checkOutput("idle after last beat", {61'd0, out_valid, busy, out_last}, 64'd0);
                idle_next = 1'b0;
            end
            if (stall_prev) begin
                checkOutput("stall hold", {46'd0, out_valid, out_last, out_data},
                            {46'd0, 1'b1, held_last, held_data});
            end
            if (out_valid && out_ready) begin
                xfers++;
                stall_prev = 1'b0;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected beat: got %0h last=%0b expected none", out_data, out_last);
                end else begin
                    logic [WORD:0] e;
                    e = expq.pop_front();
                    checkOutput("beat", {47'd0, out_last, out_data}, {47'd0, e});
                    if (out_last) idle_next = 1'b1;
                end
            end else if (out_valid) begin
                stall_prev = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int x0;
        bit seen;
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset outputs", {60'd0, busy, err, out_valid, out_last}, 64'd0);
        checkOutput("reset data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Flag 00, continuous ready
        out_ready = 1'b1;
        pushBeat(16'hCDEF, 1'b0);
        pushBeat(16'h89AB, 1'b0);
        pushBeat(16'h4567, 1'b0);
        pushBeat(16'h0123, 1'b1);
        applyStimulus(2'b00, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        runStream("flag00", 3 + LAT);

        // Flag 11 with back-pressure
        out_ready = 1'b0;
        pushBeat(16'h4444, 1'b0);
        pushBeat(16'h3333, 1'b0);
        pushBeat(16'h2222, 1'b0);
        pushBeat(16'h1111, 1'b1);
        x0 = xfers;
        applyStimulus(2'b11, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flag11 valid seen", 64'(seen), 64'd1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            out_ready = pat[i];
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("flag11 transfers", 64'(xfers - x0), 64'd4);
        checkOutput("flag11 idle", {62'd0, busy, out_valid}, 64'd0);

        // Invalid flag
        applyStimulus(2'b10, 64'h1234, 64'h1234, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        checkOutput("err pulse", {61'd0, err, busy, out_valid}, 64'b100);
        @(negedge clk);
        checkOutput("err cleared", {61'd0, err, busy, out_valid}, 64'b000);

        // Flag 01, ignored restart, then reset mid-stream
        pushBeat(16'hDDDD, 1'b0);
        pushBeat(16'hCCCC, 1'b0);
        applyStimulus(2'b01, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (LAT) @(posedge clk);
        #1;
        start = 1'b1;
        minv_flag = 2'b01;
        regx2 = 64'h5555_6666_7777_8888;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", {60'd0, busy, err, out_valid, out_last}, 64'd0);
        checkOutput("abort data", 64'(out_data), 64'd0);
        checkOutput("abort queue drained", 64'(expq.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("no resend after reset", {62'd0, out_valid, busy}, 64'd0);
        end

        // Small value against p=97
        pushBeat(SMALL_BEAT0, 1'b0);
        pushBeat(16'h0000, 1'b0);
        pushBeat(16'h0000, 1'b0);
        pushBeat(16'h0000, 1'b1);
        applyStimulus(2'b00, 64'd150, 64'h0, 64'h0, 64'd97);
        runStream("reduce97", 3 + LAT);

        // Value equal to p
        pushBeat(EQUAL_BEAT0, 1'b0);
        pushBeat(16'h0000, 1'b0);
        pushBeat(16'h0000, 1'b0);
        pushBeat(16'h0000, 1'b1);
        applyStimulus(2'b00, 64'd150, 64'h0, 64'h0, 64'd150);
        runStream("equal_p", 3 + LAT);

        @(negedge clk);
        checkOutput("final queue empty", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
